// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, constants and round helpers for the block responder.
// SHA1_TWO_ROUNDS_EN selects two compression rounds per clock.
package sha1_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} sha1_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } sha1_work_t;

  localparam logic [31:0] H_INIT [0:4] = '{
    32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
  };

`ifdef SHA1_TWO_ROUNDS_EN
  localparam int ROUNDS_PER_CYCLE = 2;
`else
  localparam int ROUNDS_PER_CYCLE = 1;
`endif

  localparam logic [6:0] T_STEP = 7'(ROUNDS_PER_CYCLE);
  localparam logic [6:0] T_LAST = 7'(80 - ROUNDS_PER_CYCLE);

  function automatic bit msg_bits_ok(input int n);
    return (n % 8 == 0) && (n >= 8) && (n <= 440);
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] k_const(input logic [6:0] t);
    if (t < 7'd20)      return 32'h5A827999;
    else if (t < 7'd40) return 32'h6ED9EBA1;
    else if (t < 7'd60) return 32'h8F1BBCDC;
    else                return 32'hCA62C1D6;
  endfunction

  function automatic logic [31:0] f_round(input logic [6:0] t, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic sha1_work_t sha1_round(input sha1_work_t s, input logic [6:0] t,
                                            input logic [31:0] w);
    sha1_work_t r;
    r.a = rotl32(s.a, 5) + f_round(t, s.b, s.c, s.d) + s.e + k_const(t) + w;
    r.b = s.a;
    r.c = rotl32(s.b, 30);
    r.d = s.c;
    r.e = s.d;
    return r;
  endfunction

endpackage

// File: rtl/sha1_msg_schedule.sv
// 16-word sliding message schedule; W[t] is always window word 0.
// With SHA1_TWO_ROUNDS_EN the window advances by two words and also exposes W[t+1].
module sha1_msg_schedule
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  input  logic [511:0] block,
  output logic [31:0]  w0
`ifdef SHA1_TWO_ROUNDS_EN
  ,
  output logic [31:0]  w1
`endif
);

  logic [31:0] win_q [0:15];
  logic [31:0] win_d [0:15];
  logic [31:0] blk_word [0:15];

  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    assign blk_word[gi] = block[511 - 32*gi -: 32];
  end

  always_comb begin
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (load) begin
      for (int i = 0; i < 16; i++) win_d[i] = blk_word[i];
    end else if (advance) begin
`ifdef SHA1_TWO_ROUNDS_EN
      for (int i = 0; i < 14; i++) win_d[i] = win_q[i+2];
      // W[t+17] only needs words already in the window, so both new words are independent
      win_d[14] = rotl32(win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0], 1);
      win_d[15] = rotl32(win_q[14] ^ win_q[9] ^ win_q[3] ^ win_q[1], 1);
`else
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = rotl32(win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0], 1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign w0 = win_q[0];
`ifdef SHA1_TWO_ROUNDS_EN
  assign w1 = win_q[1];
`endif

endmodule

// File: rtl/sha1_block_responder.sv
// Single-block SHA-1 engine behind a hashGo/hashReady/hashDone handshake.
// SHA1_TWO_ROUNDS_EN halves the ROUND phase by computing two rounds per clock.
module sha1_block_responder
  import sha1_pkg::*;
#(
  parameter int MSG_BITS  = 144,
  parameter int HASH_SIZE = 160
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hashGo,
  input  logic [MSG_BITS-1:0]  hashedVal,
  output logic                 hashReady,
  output logic                 hashDone,
  output logic [HASH_SIZE-1:0] hashedOut
);

  if (HASH_SIZE != 160) begin : g_bad_hash_size
    $error("sha1_block_responder: HASH_SIZE must be 160");
  end
  if (!msg_bits_ok(MSG_BITS)) begin : g_bad_msg_bits
    $error("sha1_block_responder: MSG_BITS must be a multiple of 8 in 8..440");
  end

  sha1_state_e         state_q, state_d;
  logic [MSG_BITS-1:0] msg_q, msg_d;
  sha1_work_t          work_q, work_d, work_step;
  logic [6:0]          t_q, t_d;
  logic [159:0]        digest_q, digest_d;
  logic                done_q, done_d;
  logic [511:0]        block;
  logic [31:0]         w0;

  // Padded single block: message, a '1' bit, zero fill, 64-bit length
  always_comb begin
    block = '0;
    block[511 -: MSG_BITS] = msg_q;
    block[511 - MSG_BITS] = 1'b1;
    block[63:0] = 64'(MSG_BITS);
  end

`ifdef SHA1_TWO_ROUNDS_EN
  logic [31:0] w1;
  sha1_msg_schedule u_sched (
    .clk(clk), .rst(rst), .load(state_q == LOAD), .advance(state_q == ROUND),
    .block(block), .w0(w0), .w1(w1)
  );
  assign work_step = sha1_round(sha1_round(work_q, t_q, w0), t_q + 7'd1, w1);
`else
  sha1_msg_schedule u_sched (
    .clk(clk), .rst(rst), .load(state_q == LOAD), .advance(state_q == ROUND),
    .block(block), .w0(w0)
  );
  assign work_step = sha1_round(work_q, t_q, w0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hashGo) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (t_q == T_LAST) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hashReady = (state_q == IDLE);
    msg_d     = msg_q;
    work_d    = work_q;
    t_d       = t_q;
    digest_d  = digest_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hashGo) begin
          msg_d    = hashedVal;
          digest_d = '0;
        end
      end
      LOAD: begin
        work_d = {H_INIT[0], H_INIT[1], H_INIT[2], H_INIT[3], H_INIT[4]};
        t_d    = '0;
      end
      ROUND: begin
        work_d = work_step;
        t_d    = t_q + T_STEP;
      end
      FINAL: begin
        digest_d = {H_INIT[0] + work_q.a, H_INIT[1] + work_q.b, H_INIT[2] + work_q.c,
                    H_INIT[3] + work_q.d, H_INIT[4] + work_q.e};
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q    <= '0;
      work_q   <= '0;
      t_q      <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      msg_q    <= msg_d;
      work_q   <= work_d;
      t_q      <= t_d;
      digest_q <= digest_d;
      done_q   <= done_d;
    end
  end

  assign hashDone  = done_q;
  assign hashedOut = digest_q;

endmodule

// File: tb/tb_sha1_block_responder.sv
// Scoreboard bench for sha1_block_responder with 24-, 344- and 144-bit message instances.
module tb_sha1_block_responder;

`ifdef SHA1_TWO_ROUNDS_EN
  localparam int LAT = 42;
`else
  localparam int LAT = 82;
`endif

  localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] FOX_DIG = 160'h2fd4e1c67a2d28fced849ee1bb76e7391b93eb12;

  typedef struct packed {
    logic [1:0]   inst;
    logic [159:0] dig;
    int           acc;
  } sb_entry_t;

  logic         clk;
  logic         rst;
  logic         go_r [3];
  logic         ready_w [3];
  logic         done_w [3];
  logic [159:0] out_w [3];
  logic [23:0]  val24;
  logic [343:0] val344;
  logic [143:0] val144;

  sb_entry_t sb_q [$];
  int        done_cnt [3];
  int        cyc;
  int        n_tests;
  int        n_fail;

  sha1_block_responder #(.MSG_BITS(24)) u_dut24 (
    .clk(clk), .rst(rst), .hashGo(go_r[0]), .hashedVal(val24),
    .hashReady(ready_w[0]), .hashDone(done_w[0]), .hashedOut(out_w[0])
  );
  sha1_block_responder #(.MSG_BITS(344)) u_dut344 (
    .clk(clk), .rst(rst), .hashGo(go_r[1]), .hashedVal(val344),
    .hashReady(ready_w[1]), .hashDone(done_w[1]), .hashedOut(out_w[1])
  );
  sha1_block_responder u_dut144 (
    .clk(clk), .rst(rst), .hashGo(go_r[2]), .hashedVal(val144),
    .hashReady(ready_w[2]), .hashDone(done_w[2]), .hashedOut(out_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Straight-line reference: full 80-word expansion, no sliding window
  function automatic logic [159:0] sha1_ref(input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp, x;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {x[30:0], x[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {32'h67452301 + a, 32'hEFCDAB89 + b, 32'h98BADCFE + c,
            32'h10325476 + d, 32'hC3D2E1F0 + e};
  endfunction

  function automatic logic [511:0] blk144(input logic [143:0] m);
    return {m, 1'b1, 303'b0, 64'd144};
  endfunction

  // Called at a negedge; pulses go for one cycle and returns at the following negedge
  task automatic send(input int i, input logic [159:0] dig, input bit expect_accept);
    sb_entry_t e;
    if (expect_accept) begin
      e.inst = 2'(i);
      e.dig  = dig;
      e.acc  = cyc + 1;
      sb_q.push_back(e);
    end
    go_r[i] = 1'b1;
    @(negedge clk);
    go_r[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int target);
    for (int k = 0; k < 400; k++) begin
      if (done_cnt[i] >= target) break;
      @(negedge clk);
    end
    check("done_seen", 160'(done_cnt[i] >= target), 160'd1);
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) begin
        int idx;
        idx = -1;
        done_cnt[i]++;
        for (int j = 0; j < sb_q.size(); j++) begin
          if (sb_q[j].inst == 2'(i)) begin
            idx = j;
            break;
          end
        end
        if (idx < 0) begin
          check("spurious_done", 160'd1, 160'd0);
        end else begin
          sb_entry_t e;
          e = sb_q[idx];
          sb_q.delete(idx);
          check("digest", out_w[i], e.dig);
          check("latency", 160'(cyc - e.acc), 160'(LAT));
          $display("[TB] inst %0d digest %h latency %0d", i, out_w[i], cyc - e.acc);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 3; i++) begin
      go_r[i] = 1'b0;
      done_cnt[i] = 0;
    end
    rst    = 1'b1;
    val24  = '0;
    val344 = '0;
    val144 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 160'(ready_w[i]), 160'd1);
      check("rst_done", 160'(done_w[i]), 160'd0);
      check("rst_out", out_w[i], 160'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // "abc"
    val24 = 24'h616263;
    send(0, ABC_DIG, 1'b1);
    check("busy_ready", 160'(ready_w[0]), 160'd0);
    wait_done(0, 1);
    @(negedge clk);
    check("done_pulse", 160'(done_w[0]), 160'd0);
    check("out_held", out_w[0], ABC_DIG);
    check("ready_after", 160'(ready_w[0]), 160'd1);

    // 43-byte message
    val344 = "The quick brown fox jumps over the lazy dog";
    send(1, FOX_DIG, 1'b1);
    wait_done(1, 1);

    // Back-to-back: second go issued in the completion cycle
    val144 = {128'h0, 16'h0001};
    send(2, sha1_ref(blk144(val144)), 1'b1);
    for (int k = 0; k < 200; k++) begin
      if (done_w[2] === 1'b1) break;
      @(negedge clk);
    end
    check("b2b_done", 160'(done_w[2]), 160'd1);
    check("b2b_ready", 160'(ready_w[2]), 160'd1);
    val144 = {128'h0, 16'h0002};
    send(2, sha1_ref(blk144(val144)), 1'b1);
    wait_done(2, 2);

    // go while busy must be ignored
    val144 = {128'h0, 16'h0003};
    send(2, sha1_ref(blk144(val144)), 1'b1);
    repeat (10) @(negedge clk);
    val144 = {128'hdead_beef, 16'h0004};
    send(2, 160'd0, 1'b0);
    wait_done(2, 3);
    repeat (100) @(negedge clk);
    check("single_done", 160'(done_cnt[2]), 160'd3);

    // Reset in the middle of the rounds
    val24 = 24'h616263;
    send(0, ABC_DIG, 1'b1);
    check("accept_clears_out", out_w[0], 160'd0);
    repeat (41) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 160'(ready_w[0]), 160'd1);
    check("abort_done", 160'(done_w[0]), 160'd0);
    check("abort_out", out_w[0], 160'd0);
    for (int j = sb_q.size() - 1; j >= 0; j--) begin
      if (sb_q[j].inst == 2'd0) sb_q.delete(j);
    end
    repeat (90) @(negedge clk);
    check("no_done_after_rst", 160'(done_cnt[0]), 160'd1);
    send(0, ABC_DIG, 1'b1);
    wait_done(0, 2);
    @(negedge clk);

    check("sb_empty", 160'(sb_q.size()), 160'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
